seg_mode_scanner: RTL and testbench

Mode sequencer and 8-digit 7-segment scan controller for the watch/stopwatch/alarm application. Debounces the raw mode button, cycles the application mode watch → stopwatch → alarm → watch, and time-multiplexes the shared 8-digit display between the three BCD sources. The source is switched only at scan-frame boundaries. In alarm mode, digits flagged as being edited blink. Sits between the function modules and the board's seg_dat/seg_com pins, on the 1 kHz system clock.

---
 rtl/seg_mode_scanner.sv | 95 +++++++++
 tb/tb_seg_mode_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_mode_scanner.sv
// seg_mode_scanner: debounced mode sequencer and 8-digit 7-segment scan controller
// with frame-aligned source switching and alarm-edit blinking.
module seg_mode_scanner #(
    parameter int DEB_CYCLES = 20,
    parameter int SCAN_DIV   = 1,
    parameter int BLINK_HALF = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_btn,
    input  logic [31:0] watch_bcd,
    input  logic [31:0] sw_bcd,
    input  logic [31:0] alarm_bcd,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  edit_mask,
    output logic [1:0]  mode,
    output logic        mode_chg,
    output logic [7:0]  seg_dat,
    output logic [7:0]  seg_com
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(2 * BLINK_HALF + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_HALF);

    logic [1:0]    sync;
    logic          acc;
    logic [DW-1:0] deb;
    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic [1:0]    disp_sel;
    logic [BW-1:0] blink;
    logic          flip, rise, tick, blank;
    logic [31:0]   src;
    logic [3:0]    nib;
    logic [6:0]    glyph;

    assign flip = (sync[1] != acc) && (deb == DEB_MAX);
    assign rise = flip && !acc;
    assign tick = pre == PRE_MAX;

    always_comb begin
        src   = disp_sel == 2'd2 ? alarm_bcd : disp_sel == 2'd1 ? sw_bcd : watch_bcd;
        nib   = src[{idx, 2'b00} +: 4];
        blank = blink >= BLK_HALF && disp_sel == 2'd2 && edit_mask[idx];
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync     <= '0;
            acc      <= 1'b0;
            deb      <= '0;
            mode     <= 2'd0;
            mode_chg <= 1'b0;
            pre      <= '0;
            idx      <= '0;
            disp_sel <= 2'd0;
            blink    <= '0;
            seg_dat  <= 8'h00;
            seg_com  <= 8'hFF;
        end else begin
            sync     <= {sync[0], mode_btn};
            deb      <= (sync[1] == acc || flip) ? '0 : deb + 1'b1;
            acc      <= flip ? ~acc : acc;
            mode_chg <= rise;
            if (rise)
                mode <= mode == 2'd2 ? 2'd0 : mode + 1'b1;
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                idx <= idx + 1'b1;
            // source only switches on the 7->0 wrap so a frame never mixes sources
            if (tick && idx == 3'd7)
                disp_sel <= mode;
            blink   <= (rise || blink == BLK_MAX) ? '0 : blink + 1'b1;
            seg_com <= ~(8'b1 << idx);
            seg_dat <= blank ? 8'h00 : {dp_mask[idx], glyph};
        end
    end
endmodule

// File: tb/tb_seg_mode_scanner.sv
// tb_seg_mode_scanner: table-driven scan/decode vectors plus hand-written
// debounce, mode wrap, frame switch, blink and async reset sequences.
module tb_seg_mode_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode_btn = 1'b0;
    logic [31:0] watch_bcd = '0, sw_bcd = '0, alarm_bcd = '0;
    logic [7:0]  dp_mask = '0, edit_mask = '0;
    logic [1:0]  mode;
    logic        mode_chg;
    logic [7:0]  seg_dat, seg_com;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int chg_cnt = 0;

    typedef struct {
        logic [31:0] bcd;
        logic [7:0]  dp;
        logic [63:0] exp;
    } vec_t;
    typedef struct {
        logic [7:0] com;
        logic [7:0] dat;
    } exp_t;
    vec_t vt[5];
    exp_t q[$];

    seg_mode_scanner dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn),
        .watch_bcd(watch_bcd), .sw_bcd(sw_bcd), .alarm_bcd(alarm_bcd),
        .dp_mask(dp_mask), .edit_mask(edit_mask),
        .mode(mode), .mode_chg(mode_chg), .seg_dat(seg_dat), .seg_com(seg_com)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    always @(negedge clk)
        if (mode_chg) chg_cnt <= chg_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_digit(input int d, input logic [7:0] dat);
        exp_t e;
        e.com = ~(8'b1 << d);
        e.dat = dat;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        exp_t e;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk(nm, {16'h0, seg_com, seg_dat}, {16'h0, e.com, e.dat});
        end
    endtask

    // returns at the negedge that shows digit 7, so the next negedge shows digit 0
    task automatic align();
        int k = 0;
        @(negedge clk);
        while ((cyc - 1) % 8 != 7 && k < 16) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press();
        mode_btn = 1'b1;
        repeat (40) @(negedge clk);
        mode_btn = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int base, lat, a;
        vt[0] = '{32'h76543210, 8'h00, 64'h077D6D664F5B063F};
        vt[1] = '{32'h98FEDABC, 8'h81, 64'hEF7F000000000080};
        vt[2] = '{32'h11111111, 8'hFF, 64'h8686868686868686};
        vt[3] = '{32'h22222222, 8'h0F, 64'h5B5B5B5BDBDBDBDB};
        vt[4] = '{32'h99999999, 8'h00, 64'h6F6F6F6F6F6F6F6F};

        watch_bcd = 32'h76543210;
        repeat (3) @(negedge clk);
        chk("reset_com", {24'h0, seg_com}, 32'hFF);
        chk("reset_dat", {24'h0, seg_dat}, 32'h00);
        chk("reset_mode", {30'h0, mode}, 32'h0);
        chk("reset_chg", {31'h0, mode_chg}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_digit_com", {24'h0, seg_com}, 32'hFE);
        chk("first_digit_dat", {24'h0, seg_dat}, 32'h3F);

        for (int i = 0; i < 5; i++) begin
            watch_bcd = vt[i].bcd;
            dp_mask   = vt[i].dp;
            align();
            for (int d = 0; d < 8; d++) push_digit(d, vt[i].exp[8*d +: 8]);
            drain($sformatf("vec%0d", i));
        end

        // bounces shorter than the debounce window
        dp_mask = 8'h00;
        base = chg_cnt;
        repeat (4) begin
            mode_btn = 1'b1;
            repeat (5) @(negedge clk);
            mode_btn = 1'b0;
            repeat (5) @(negedge clk);
        end
        chk("bounce_no_chg", chg_cnt - base, 0);
        chk("bounce_mode", {30'h0, mode}, 32'h0);
        mode_btn = 1'b1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (mode_chg && lat == 0) lat = n;
        end
        chk("press_latency", lat, 22);
        chk("press_one_chg", chg_cnt - base, 1);
        chk("press_mode", {30'h0, mode}, 32'h1);
        mode_btn = 1'b0;
        repeat (40) @(negedge clk);
        chk("release_no_chg", chg_cnt - base, 1);
        chk("release_mode", {30'h0, mode}, 32'h1);

        do_reset();
        base = chg_cnt;
        press();
        chk("wrap_mode1", {30'h0, mode}, 32'h1);
        press();
        chk("wrap_mode2", {30'h0, mode}, 32'h2);
        press();
        chk("wrap_mode0", {30'h0, mode}, 32'h0);
        chk("wrap_chg_count", chg_cnt - base, 3);

        // press timed so acceptance lands while digit 3 is shown
        do_reset();
        watch_bcd = 32'h11111111;
        sw_bcd    = 32'h22222222;
        a = 0;
        @(negedge clk);
        while (cyc % 8 != 6 && a < 16) begin
            @(negedge clk);
            a++;
        end
        mode_btn = 1'b1;
        repeat (22) @(negedge clk);
        chk("frame_chg", {31'h0, mode_chg}, 32'h1);
        chk("frame_com3", {24'h0, seg_com}, 32'hF7);
        chk("frame_dat3", {24'h0, seg_dat}, 32'h06);
        for (int d = 4; d < 8; d++) push_digit(d, 8'h06);
        for (int d = 0; d < 8; d++) push_digit(d, 8'h5B);
        drain("frame_switch");
        mode_btn = 1'b0;
        repeat (40) @(negedge clk);

        alarm_bcd = 32'h88888888;
        edit_mask = 8'h03;
        mode_btn  = 1'b1;
        a = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mode_chg && a < 0) a = cyc;
        end
        chk("alarm_entered", (a >= 0) ? 32'h1 : 32'h0, 32'h1);
        chk("alarm_mode", {30'h0, mode}, 32'h2);
        if (a >= 0) begin
            while (cyc < a + 600) begin
                int d, p;
                @(negedge clk);
                d = (cyc - 1) % 8;
                p = (cyc - 1 - a) % 500;
                if (cyc >= a + 10)
                    chk("blink", {16'h0, seg_com, seg_dat},
                        {16'h0, ~(8'b1 << d), (d < 2 && p >= 250) ? 8'h00 : 8'h7F});
            end
        end

        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_com", {24'h0, seg_com}, 32'hFF);
        chk("async_rst_dat", {24'h0, seg_dat}, 32'h00);
        chk("async_rst_mode", {30'h0, mode}, 32'h0);
        chk("async_rst_chg", {31'h0, mode_chg}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
